// File: rtl/irq_controller_pkg.sv
// Shared constants for the interrupt controller: register map and priority encoding.
package irq_controller_pkg;

    // Priority field width per source and the priority every source gets out of reset.
    localparam int unsigned       PRIO_W     = 2;
    localparam logic [PRIO_W-1:0] PRIO_RESET = 2'd1;

    // Index width wide enough for the largest legal source count (32).
    localparam int unsigned IDX_W = 5;

    // MMIO word addresses; all eight are mapped.
    typedef enum logic [2:0] {
        RegPending   = 3'd0,
        RegEnable    = 3'd1,
        RegMode      = 3'd2,
        RegPrioLo    = 3'd3,
        RegPrioHi    = 3'd4,
        RegThreshold = 3'd5,
        RegClaim     = 3'd6,
        RegComplete  = 3'd7
    } reg_addr_e;

endpackage

// File: rtl/irq_prio_select.sv
// Combinational winner selection: highest priority candidate, ties to the lowest index.
module irq_prio_select
    import irq_controller_pkg::*;
#(
    parameter int unsigned NSRC = 8
) (
    input  logic [NSRC-1:0]             cand,
    input  logic [NSRC-1:0][PRIO_W-1:0] prio,
    output logic                        valid,
    output logic [IDX_W-1:0]            index
);

    logic [PRIO_W-1:0] best;

    // Linear scan; a strict greater-than keeps the earlier (lower) index on ties.
    always_comb begin
        valid = 1'b0;
        index = '0;
        best  = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (cand[i] && (!valid || prio[i] > best)) begin
                valid = 1'b1;
                index = IDX_W'(i);
                best  = prio[i];
            end
        end
    end

endmodule

// File: rtl/irq_controller.sv
// Memory-mapped interrupt controller with per-source edge/level mode, enable,
// 2-bit priority, global threshold, claim/complete and a registered CPU request.
module irq_controller
    import irq_controller_pkg::*;
#(
    parameter int unsigned     NSRC       = 8,
    parameter int unsigned     TIMER_ID   = 0,
    parameter logic [NSRC-1:0] RESET_MODE = '1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NSRC-1:0] irq_src,
    input  logic [2:0]      a,
    input  logic [31:0]     d,
    input  logic            we,
    output logic [31:0]     spo,
    output logic            interrupt,
    input  logic            int_reply,
    output logic            int_istimer
);

    logic [NSRC-1:0]             pending_q, pending_d;
    logic [NSRC-1:0]             enable_q, mode_q, prev_q;
    logic [NSRC-1:0][PRIO_W-1:0] prio_q;
    logic [PRIO_W-1:0]           thresh_q;
    logic [NSRC-1:0]             rise, clr, cand;
    logic                        sel_valid;
    logic [IDX_W-1:0]            sel_idx, sel_q;
    logic                        int_q, timer_q;
    logic [31:0]                 prio_lo, prio_hi;
    reg_addr_e                   addr;
    logic wr_pending, wr_enable, wr_mode, wr_prio_lo, wr_prio_hi, wr_thresh, wr_complete;

    assign addr        = reg_addr_e'(a);
    assign wr_pending  = we && (addr == RegPending);
    assign wr_enable   = we && (addr == RegEnable);
    assign wr_mode     = we && (addr == RegMode);
    assign wr_prio_lo  = we && (addr == RegPrioLo);
    assign wr_prio_hi  = we && (addr == RegPrioHi);
    assign wr_thresh   = we && (addr == RegThreshold);
    assign wr_complete = we && (addr == RegComplete);

    assign rise = irq_src & ~prev_q;

    // Configuration registers written over MMIO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enable_q <= '0;
            mode_q   <= RESET_MODE;
            prio_q   <= {NSRC{PRIO_RESET}};
            thresh_q <= '0;
        end else begin
            if (wr_enable) enable_q <= d[NSRC-1:0];
            if (wr_mode)   mode_q   <= d[NSRC-1:0];
            if (wr_thresh) thresh_q <= d[PRIO_W-1:0];
            if (wr_prio_lo) begin
                for (int i = 0; i < NSRC && i < 16; i++) prio_q[i] <= d[2*i +: PRIO_W];
            end
            if (wr_prio_hi) begin
                for (int i = 16; i < NSRC; i++) prio_q[i] <= d[2*(i-16) +: PRIO_W];
            end
        end
    end

    // Clear requests from CPU reply (active source only), COMPLETE by index, and W1C.
    always_comb begin
        clr = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (int_q && int_reply && (sel_q == IDX_W'(i))) clr[i] = 1'b1;
            if (wr_complete && (d == 32'(i + 1)))            clr[i] = 1'b1;
        end
        if (wr_pending) clr = clr | d[NSRC-1:0];
    end

    // Edge sources: a new edge beats any clear. Level sources track the input sample.
    always_comb begin
        pending_d = pending_q;
        for (int i = 0; i < NSRC; i++) begin
            if (mode_q[i]) pending_d[i] = rise[i] | (pending_q[i] & ~clr[i]);
            else           pending_d[i] = irq_src[i];
        end
    end

    // Candidates must be pending, enabled and strictly above the threshold.
    always_comb begin
        cand = '0;
        for (int i = 0; i < NSRC; i++) begin
            cand[i] = pending_q[i] & enable_q[i] & (prio_q[i] > thresh_q);
        end
    end

    irq_prio_select #(
        .NSRC (NSRC)
    ) u_select (
        .cand  (cand),
        .prio  (prio_q),
        .valid (sel_valid),
        .index (sel_idx)
    );

    // Pending state, input history and the registered CPU request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q    <= '0;
            pending_q <= '0;
            int_q     <= 1'b0;
            sel_q     <= '0;
            timer_q   <= 1'b0;
        end else begin
            prev_q    <= irq_src;
            pending_q <= pending_d;
            int_q     <= sel_valid;
            sel_q     <= sel_idx;
            timer_q   <= sel_valid && (sel_idx == IDX_W'(TIMER_ID));
        end
    end

    // Pack per-source priorities into the two 32-bit register views.
    always_comb begin
        prio_lo = '0;
        prio_hi = '0;
        for (int i = 0; i < NSRC && i < 16; i++) prio_lo[2*i +: PRIO_W] = prio_q[i];
        for (int i = 16; i < NSRC; i++) prio_hi[2*(i-16) +: PRIO_W] = prio_q[i];
    end

    // Combinational read mux.
    always_comb begin
        spo = '0;
        unique case (addr)
            RegPending:   spo = 32'(pending_q);
            RegEnable:    spo = 32'(enable_q);
            RegMode:      spo = 32'(mode_q);
            RegPrioLo:    spo = prio_lo;
            RegPrioHi:    spo = prio_hi;
            RegThreshold: spo = 32'(thresh_q);
            RegClaim:     spo = sel_valid ? 32'(sel_idx) + 32'd1 : 32'd0;
            RegComplete:  spo = '0;
            default:      spo = '0;
        endcase
    end

    assign interrupt   = int_q;
    assign int_istimer = timer_q;

endmodule
